// File: rtl/serial_add_sub.sv
// serial_add_sub
//   Bit-serial two's-complement adder/subtractor built around one full-adder
//   cell and a one-bit carry register. Operands are consumed LSB first, one bit
//   per clock. A W-bit operation takes W+1 clock edges from the start edge to
//   the done pulse.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while idle
//   sub       0 = a+b, 1 = a-b, sampled with start
//   a, b      W-bit operands, sampled with start
//   busy      high while operand bits are being processed
//   done      single-cycle completion pulse
//   result    registered sum/difference, held until the next done
//   cout      carry out of the MSB (for subtraction, 1 = no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)

module serial_add_sub #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow
);

  localparam int CW = $clog2(W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  logic [1:0]    state;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [W-1:0]  acc;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [W-1:0]  result_q;
  logic          cout_q;
  logic          overflow_q;

  logic          bit_sum;
  logic          bit_carry;
  logic [W-1:0]  acc_next;

  // Full-adder cell for the current bit position.
  assign bit_sum   = sa[0] ^ sb[0] ^ carry;
  assign bit_carry = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
  assign acc_next  = {bit_sum, acc[W-1:1]};

  // Subtraction is a + ~b + 1. The +1 comes from preloading the carry with 1.
  // On the MSB edge, the carry register still holds the carry into the MSB.
  // That lets the overflow flag be formed from it and the new carry, with no
  // separate cin_msb register. The result is loaded from acc_next so that it
  // is already visible during the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      acc        <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= sub ? ~b : b;
            acc   <= '0;
            carry <= sub;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          acc   <= acc_next;
          carry <= bit_carry;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            result_q   <= acc_next;
            cout_q     <= bit_carry;
            overflow_q <= carry ^ bit_carry;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub
//   Self-checking bench for serial_add_sub with W=4. It runs directed cases
//   and random operations. Results are compared against an integer-arithmetic
//   reference model. The bench also checks done/busy timing, that operands
//   are latched, that start is ignored while busy, and mid-operation reset.

module tb_serial_add_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int checks = 0;
  int failures = 0;

  serial_add_sub #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Returns {overflow, cout, result}, computed with plain signed and unsigned arithmetic.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_sub);
    int ua;
    int ub;
    int sa_v;
    int sb_v;
    int full;
    int sres;
    logic [W-1:0] r;
    logic c;
    logic ov;
    ua   = int'(op_a);
    ub   = int'(op_b);
    sa_v = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb_v = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    full = op_sub ? (ua - ub + (1 << W)) : (ua + ub);
    c    = (full >= (1 << W));
    r    = W'(full % (1 << W));
    sres = op_sub ? (sa_v - sb_v) : (sa_v + sb_v);
    ov   = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
    return {ov, c, r};
  endfunction

  // Issues one operation and watches it to completion. Operand inputs are
  // scrambled after the start edge. An optional stray start pulse can be
  // injected at negedge number inject_at.
  task automatic applyStimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_sub,
                               input int inject_at, input string tag);
    logic [W+1:0] exp;
    logic [W-1:0] cap_res;
    logic         cap_cout;
    logic         cap_ovf;
    int busy_cycles;
    int done_cycles;
    int done_at;
    exp         = ref_model(op_a, op_b, op_sub);
    busy_cycles = 0;
    done_cycles = 0;
    done_at     = -1;
    cap_res     = '0;
    cap_cout    = 1'b0;
    cap_ovf     = 1'b0;
    @(negedge clk);
    a     = op_a;
    b     = op_b;
    sub   = op_sub;
    start = 1'b1;
    for (int i = 1; i <= W + 3; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_cycles++;
        if (done_at < 0) begin
          done_at  = i;
          cap_res  = result;
          cap_cout = cout;
          cap_ovf  = overflow;
        end
      end
      start = (inject_at != 0) && (i == inject_at);
      if (start) begin
        a   = 4'b0001;
        b   = 4'b0001;
        sub = 1'b0;
      end else begin
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
      end
    end
    start = 1'b0;
    checkOutput({tag, ".busy_cycles"}, busy_cycles, W);
    checkOutput({tag, ".done_cycles"}, done_cycles, 1);
    checkOutput({tag, ".done_at"}, done_at, W + 1);
    checkOutput({tag, ".result"}, cap_res, exp[W-1:0]);
    checkOutput({tag, ".cout"}, cap_cout, exp[W]);
    checkOutput({tag, ".overflow"}, cap_ovf, exp[W+1]);
    checkOutput({tag, ".held"}, result, exp[W-1:0]);
  endtask

  initial begin
    int no_done;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.done", done, 0);
    checkOutput("rst.result", result, 0);
    checkOutput("rst.cout", cout, 0);
    checkOutput("rst.overflow", overflow, 0);
    rst_n = 1'b1;

    // Directed cases, including the stray start during busy (T5)
    applyStimulus(4'b0101, 4'b0011, 1'b0, 0, "T1");
    checkOutput("T1.const", {overflow, cout, result}, {1'b1, 1'b0, 4'b1000});
    applyStimulus(4'b1111, 4'b0001, 1'b0, 0, "T2");
    checkOutput("T2.const", {overflow, cout, result}, {1'b0, 1'b1, 4'b0000});
    applyStimulus(4'b0011, 4'b0101, 1'b1, 0, "T3");
    checkOutput("T3.const", {overflow, cout, result}, {1'b0, 1'b0, 4'b1110});
    applyStimulus(4'b1000, 4'b0001, 1'b1, 2, "T5");
    checkOutput("T5.const", {overflow, cout, result}, {1'b1, 1'b1, 4'b0111});
    checkOutput("T5.idle_after", busy, 0);

    // Mid-operation reset (T6)
    @(negedge clk);
    a     = 4'b0101;
    b     = 4'b0011;
    sub   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("T6.busy1", busy, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("T6.rst_busy", busy, 0);
    checkOutput("T6.rst_outs", {done, overflow, cout, result}, 7'd0);
    no_done = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done) no_done++;
    end
    checkOutput("T6.no_done", no_done, 0);
    rst_n = 1'b1;
    applyStimulus(4'b0010, 4'b0010, 1'b0, 0, "T6b");
    checkOutput("T6b.const", {overflow, cout, result}, {1'b0, 1'b0, 4'b0100});

    // Random operations
    for (int n = 0; n < 40; n++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 0, $sformatf("R%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
